// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI serial-memory master/slave pair.
package spi_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Bits per frame: one rw bit, then the address, then the data field.
   function automatic int frame_bits(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider for sclk; idles low and holds its count at zero when disabled.
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             tick;

   // Count clk cycles in the half period; toggle sclk when the half period expires.
   always_comb begin
      cnt_d    = cnt_q;
      sclk_d   = sclk_q;
      tick     = en && (cnt_q == CNT_W'(CLK_DIV - 1));
      rise_stb = tick && !sclk_q;
      fall_stb = tick && sclk_q;
      if (!en) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         cnt_d  = '0;
         sclk_d = !sclk_q;
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   // Divider state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_mem.sv
// SPI mode-0 master: serializes {rw, addr, wdata} MSB first and captures the read data field.
module spi_master_mem
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              cs,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);

   localparam int FRAME    = frame_bits(ADDR_W, DATA_W);
   localparam int BIT_W    = $clog2(FRAME);
   localparam int WAIT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   state_e            state_q, state_d;
   logic [FRAME-1:0]  sh_q, sh_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              rw_q, rw_d;
   logic              cs_q, cs_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sclk_en, rise_stb, fall_stb;

   // sclk only runs while bits are being shifted, so it can never be high with cs released.
   assign sclk_en = (state_q == SHIFT);

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (sclk_en),
      .sclk     (sclk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Frame sequencing: load, shift on sclk edges, hold cs for a half period, then enforce the gap.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      bit_d   = bit_q;
      wait_d  = wait_q;
      rw_d    = rw_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               // mosi is the MSB of the shift register, so loading it also presents bit FRAME-1.
               sh_d    = {rw, addr, (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}}};
               rw_d    = rw;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               bit_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rise_stb) begin
               rx_d = DATA_W'({rx_q, miso});
            end
            if (fall_stb) begin
               if (bit_q == BIT_W'(FRAME - 1)) begin
                  sh_d    = '0;
                  wait_d  = '0;
                  state_d = HOLD;
               end else begin
                  sh_d  = sh_q << 1;
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         HOLD: begin
            if (wait_q == WAIT_W'(CLK_DIV - 1)) begin
               cs_d    = 1'b1;
               done_d  = 1'b1;
               wait_d  = '0;
               state_d = GAP;
               if (rw_q == RW_READ) begin
                  rdata_d = rx_q;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         GAP: begin
            if (wait_q == WAIT_W'(CS_GAP - 1)) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         bit_q   <= '0;
         wait_q  <= '0;
         rw_q    <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         bit_q   <= bit_d;
         wait_q  <= wait_d;
         rw_q    <= rw_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mosi  = sh_q[FRAME-1];
   assign cs    = cs_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_mem.sv
// Directed + randomized bench for spi_master_mem with a behavioural serial-memory slave.
module tb_spi_master_mem;
   import spi_mem_pkg::*;

   localparam int FR       = frame_bits(8, 8);
   localparam int CLK_DIV  = 2;
   localparam int CS_GAP   = 4;
   localparam int EXP_DONE = 1 + 2 * FR * CLK_DIV + CLK_DIV;  // cycle cs rises / done pulses
   localparam int EXP_IDLE = EXP_DONE + CS_GAP;               // cycle busy drops

   logic       clk;
   logic       rst, start, rw, busy, done, cs, sclk, mosi, miso;
   logic [7:0] addr, wdata, rdata;
   logic       rst1, start1, rw1, busy1, done1, cs1, sclk1, mosi1, miso1;
   logic [7:0] addr1, wdata1, rdata1;

   spi_master_mem #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso));

   spi_master_mem #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(1), .CS_GAP(CS_GAP)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
      .busy(busy1), .done(done1), .rdata(rdata1), .cs(cs1), .sclk(sclk1), .mosi(mosi1), .miso(miso1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] init_val(input int i);
      return 8'((i * 29) + 71);
   endfunction

   // Behavioural slave memory: samples mosi on sclk rise, drives miso after sclk fall.
   logic [7:0]  slv_mem [256];
   logic        slv_init = 1'b0;
   logic        slv_miso = 1'b0;
   logic        s_prev   = 1'b0;
   logic [16:0] s_sh     = '0;
   logic        s_rw     = 1'b0;
   logic [7:0]  s_addr   = '0;
   int          s_cnt    = 0;
   logic        miso_force;
   assign miso = miso_force | slv_miso;

   always @(negedge clk) begin
      logic [7:0] m;
      if (!slv_init) begin
         for (int i = 0; i < 256; i++) slv_mem[i] = init_val(i);
         slv_init = 1'b1;
      end
      if (cs) begin
         s_cnt = 0; s_sh = '0; slv_miso = 1'b0;
      end else begin
         if (sclk && !s_prev) begin
            s_sh = {s_sh[15:0], mosi};
            s_cnt++;
            if (s_cnt == 9) begin s_rw = s_sh[8]; s_addr = s_sh[7:0]; end
            if (s_cnt == FR && s_rw) slv_mem[s_addr] = s_sh[7:0];
         end
         if (!sclk && s_prev && s_cnt >= 9 && s_cnt < FR && !s_rw) begin
            m = slv_mem[s_addr];
            slv_miso = m[7 - (s_cnt - 9)];
         end
      end
      s_prev = sclk;
   end

   // Reference model state.
   logic [7:0]  ref_mem [256];
   logic [7:0]  exp_rdata;
   logic [16:0] exp_frame;

   // Observations of the last frame.
   logic [16:0] cap;
   logic [7:0]  rdata_done;
   int rises, cs_lo_t, cs_hi_t, done_t, done_cnt, busy_lo_t, cs_lo2_t, gap_cycles, viol, txn_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start and watch cycles 1.. after acceptance; stops when busy drops
   // (or, with hold, when the next frame pulls cs low).
   task automatic run_frame(input logic rw_i, input logic [7:0] a_i, input logic [7:0] d_i,
                            input int pa, input int pb, input int rst_at, input bit hold);
      logic sp;
      int   t;
      bit   fin;
      cap = '0; rises = 0; cs_lo_t = -1; cs_hi_t = -1; done_t = -1; done_cnt = 0;
      busy_lo_t = -1; cs_lo2_t = -1; gap_cycles = 0; viol = 0; rdata_done = 'x;
      @(negedge clk);
      start = 1'b1; rw = rw_i; addr = a_i; wdata = d_i;
      sp = 1'b0; t = 0; fin = 1'b0;
      while (t < 400 && !fin) begin
         @(negedge clk);
         t++;
         if (!hold) begin
            start = (t == pa || t == pb);
            rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
         end
         if (t == rst_at) rst = 1'b1;
         if (t == rst_at + 1) begin
            rst = 1'b0;
            chk("rst_mid_cs", 32'(cs), 32'd1);
            chk("rst_mid_sclk", 32'(sclk), 32'd0);
            chk("rst_mid_busy", 32'(busy), 32'd0);
            chk("rst_mid_done", 32'(done), 32'd0);
         end
         if (sclk && cs) viol++;
         if (sclk && !sp) begin cap = {cap[15:0], mosi}; rises++; end
         sp = sclk;
         if (!cs && cs_lo_t < 0) cs_lo_t = t;
         if (cs && cs_lo_t > 0 && cs_hi_t < 0) cs_hi_t = t;
         if (done) begin
            done_cnt++;
            if (done_t < 0) begin done_t = t; rdata_done = rdata; end
         end
         if (cs_hi_t > 0 && cs_lo2_t < 0 && cs && busy) gap_cycles++;
         if (cs_hi_t > 0 && cs_lo2_t < 0 && !cs) cs_lo2_t = t;
         if (t > 1 && !busy && busy_lo_t < 0) busy_lo_t = t;
         fin = hold ? (cs_lo2_t > 0) : (busy_lo_t > 0);
      end
      start = 1'b0;
      checks++;
      assert (fin) else begin errors++; $error("FAIL frame_timeout observed=%0d expected<400", t); end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      checks++;
      assert (!busy) else begin errors++; $error("FAIL idle_timeout observed=%0d expected<500", n); end
   endtask

   // Full transaction with spec-derived timing and the memory model.
   task automatic txn(input logic rw_i, input logic [7:0] a_i, input logic [7:0] d_i,
                      input int pa, input int pb);
      run_frame(rw_i, a_i, d_i, pa, pb, -1, 1'b0);
      exp_frame = {rw_i, a_i, rw_i ? d_i : 8'h00};
      if (rw_i) ref_mem[a_i] = d_i;
      else exp_rdata = miso_force ? 8'hFF : ref_mem[a_i];
      chk("frame_bits", 32'(cap), 32'(exp_frame));
      chk("sclk_rises", 32'(rises), 32'(FR));
      chk("cs_low_t", 32'(cs_lo_t), 32'd1);
      chk("cs_high_t", 32'(cs_hi_t), 32'(EXP_DONE));
      chk("done_t", 32'(done_t), 32'(EXP_DONE));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("busy_low_t", 32'(busy_lo_t), 32'(EXP_IDLE));
      chk("sclk_with_cs_high", 32'(viol), 32'd0);
      chk("rdata_at_done", 32'(rdata_done), 32'(exp_rdata));
      txn_n++;
      $display("txn %0d rw=%0d addr=%02h wdata=%02h rdata=%02h done_t=%0d", txn_n, rw_i, a_i, d_i,
               rdata_done, done_t);
   endtask

   int lo1, d1, r1, rt1, rt2, bl1, n_low;
   logic p1;
   logic [16:0] cap1;

   initial begin
      rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; miso_force = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0; miso1 = 1'b0;
      txn_n = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      exp_rdata = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_cs", 32'(cs), 32'd1);
      chk("reset_sclk", 32'(sclk), 32'd0);
      chk("reset_mosi", 32'(mosi), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rdata", 32'(rdata), 32'd0);
      chk("reset_cs_div1", 32'(cs1), 32'd1);
      rst = 1'b0; rst1 = 1'b0;

      // Directed write then read-back.
      txn(1'b1, 8'h05, 8'h3C, -1, -1);
      txn(1'b0, 8'h05, 8'h00, -1, -1);
      chk("readback_05", 32'(rdata), 32'h3C);

      // Slave line stuck high: read returns all ones, a following write leaves rdata alone.
      miso_force = 1'b1;
      txn(1'b0, 8'($urandom), 8'h00, -1, -1);
      txn(1'b1, 8'h40, 8'($urandom), -1, -1);
      chk("rdata_after_write", 32'(rdata), 32'hFF);
      miso_force = 1'b0;

      // Starts during a frame are ignored.
      txn(1'b1, 8'h11, 8'hA7, 10, 40);
      n_low = 0;
      repeat (8) begin @(negedge clk); if (!cs) n_low++; end
      chk("no_queued_frame", 32'(n_low), 32'd0);

      // Reset in the middle of a write.
      run_frame(1'b1, 8'h22, 8'h99, -1, -1, 30, 1'b0);
      chk("rst_no_done", 32'(done_cnt), 32'd0);
      exp_rdata = 8'h00;
      chk("rst_rdata_cleared", 32'(rdata), 32'(exp_rdata));
      txn(1'b1, 8'h22, 8'h99, -1, -1);
      txn(1'b0, 8'h22, 8'h00, -1, -1);

      // start held high: next frame begins right after the busy gap.
      run_frame(1'b1, 8'h30, 8'h5A, -1, -1, -1, 1'b1);
      ref_mem[8'h30] = 8'h5A;
      chk("b2b_frame_bits", 32'(cap), 32'h1305A);
      chk("b2b_cs_high_t", 32'(cs_hi_t), 32'(EXP_DONE));
      chk("b2b_gap_cycles", 32'(gap_cycles), 32'(CS_GAP));
      chk("b2b_busy_low_t", 32'(busy_lo_t), 32'(EXP_IDLE));
      chk("b2b_next_cs_low_t", 32'(cs_lo2_t), 32'(EXP_IDLE + 1));
      wait_idle();
      txn(1'b0, 8'h30, 8'h00, -1, -1);

      // Randomized traffic over a small address window so reads hit earlier writes.
      for (int k = 0; k < 10; k++)
         txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), -1, -1);

      // CLK_DIV=1 instance: sclk period 2 clk, done at 1 + 2*FRAME + 1.
      rw1 = 1'b1; addr1 = 8'hA5; wdata1 = 8'h0F;
      @(negedge clk); start1 = 1'b1;
      lo1 = -1; d1 = -1; r1 = 0; rt1 = -1; rt2 = -1; bl1 = -1; p1 = 1'b0; cap1 = '0;
      for (int t = 1; t <= 200 && bl1 < 0; t++) begin
         @(negedge clk);
         if (t == 1) start1 = 1'b0;
         if (!cs1 && lo1 < 0) lo1 = t;
         if (sclk1 && !p1) begin
            cap1 = {cap1[15:0], mosi1}; r1++;
            if (r1 == 1) rt1 = t;
            if (r1 == 2) rt2 = t;
         end
         p1 = sclk1;
         if (done1 && d1 < 0) d1 = t;
         if (t > 1 && !busy1) bl1 = t;
      end
      chk("div1_cs_low_t", 32'(lo1), 32'd1);
      chk("div1_first_rise_t", 32'(rt1), 32'd2);
      chk("div1_sclk_period", 32'(rt2 - rt1), 32'd2);
      chk("div1_rises", 32'(r1), 32'(FR));
      chk("div1_frame_bits", 32'(cap1), 32'h1A50F);
      chk("div1_done_t", 32'(d1), 32'd36);
      chk("div1_busy_low_t", 32'(bl1), 32'(36 + CS_GAP));
      $display("txn div1 rw=1 addr=a5 wdata=0f done_t=%0d", d1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
